// File: rtl/mem_responder.sv
// Memory-side responder: one read/write per transaction. Each request waits a
// fixed number of wait states, then accesses a 16-bit word array. The result
// is returned on a valid/ready response channel.
module mem_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                  MEM_clock,
  input  logic                  MEM_reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error,
  input  logic                  resp_ready,
  output logic                  busy
);

  // Array index width; the address is truncated only after the range check.
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  resp_error_q, resp_error_d;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic                  mem_we;
  logic                  in_range;
  logic [IDX_W-1:0]      idx;

  assign in_range = (32'(addr_q) < 32'(MEM_DEPTH));
  assign idx      = addr_q[IDX_W-1:0];

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_error = resp_error_q;

  // Next-state and datapath: accept in IDLE, count down in WAIT, hold in RESP
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_error_d = resp_error_q;
    mem_we       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          write_d = req_write;
          wdata_d = req_wdata;
          cnt_d   = 4'(WAIT_STATES);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          if (!in_range) begin
            resp_rdata_d = '0;
            resp_error_d = 1'b1;
          end else if (write_q) begin
            // Reset blocks the commit, so a write aborted at this edge never lands.
            mem_we       = !MEM_reset;
            resp_rdata_d = wdata_q;
            resp_error_d = 1'b0;
          end else begin
            resp_rdata_d = mem_q[idx];
            resp_error_d = 1'b0;
          end
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and response registers, synchronously reset
  always_ff @(posedge MEM_clock) begin
    if (MEM_reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
    end
  end

  // Word array: no reset, so contents survive MEM_reset
  always_ff @(posedge MEM_clock) begin
    if (mem_we) mem_q[idx] <= wdata_q;
  end

endmodule
